// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial adder/subtractor.
// A request on start loads a, b and sub. The block then processes one bit
// per cycle, LSB first, for WIDTH cycles and presents the registered result
// during a one-cycle DONE state.
//
// Ports:
//   clk    - clock; all state changes happen on the rising edge
//   resetn - asynchronous active-low reset
//   start  - level request; sampled only in IDLE and DONE
//   sub    - 0: a+b, 1: a-b (captured in LOAD)
//   a, b   - WIDTH-bit operands (captured in LOAD)
//   busy   - high in LOAD and SHIFT
//   done   - one-cycle pulse in DONE
//   sum    - registered WIDTH-bit result
//   cout   - registered final carry (subtract: 1 = no borrow)
//   ovf    - registered two's-complement overflow
module serial_addsub #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned    CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             sub_q, sub_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    // Single-bit full adder on the current LSBs
    logic bb, s, cnext;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        // Subtraction is a + ~b + 1; the +1 comes from carry preset to sub
        bb    = b_q[0] ^ sub_q;
        s     = a_q[0] ^ bb ^ carry_q;
        cnext = (a_q[0] & bb) | (a_q[0] & carry_q) | (bb & carry_q);

        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                a_d     = a;
                b_d     = b;
                sub_d   = sub;
                carry_d = sub;
                cnt_d   = '0;
                res_d   = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                res_d   = {s, res_q[WIDTH-1:1]};
                carry_d = cnext;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // Last bit is the MSB: carry_q is its carry-in, cnext its carry-out
                    state_d = S_DONE;
                    sum_d   = {s, res_q[WIDTH-1:1]};
                    cout_d  = cnext;
                    ovf_d   = carry_q ^ cnext;
                end
            end
            S_DONE: begin
                state_d = start ? S_LOAD : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q == S_LOAD) || (state_q == S_SHIFT);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving operand/result width in bits; legal range 2..64.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-003 The block SHALL have port resetn, input, 1, reset that is asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1, a level request sampled only in IDLE and DONE.
REQ-005 The block SHALL have port sub, input, 1, mode select: 0 = a+b, 1 = a-b; captured in LOAD.
REQ-006 The block SHALL have ports a and b, input, WIDTH each, operands captured in LOAD.
REQ-007 The block SHALL have port busy, output, 1, high in LOAD and SHIFT.
REQ-008 The block SHALL have port done, output, 1, a one-cycle pulse in DONE.
REQ-009 The block SHALL have port sum, output, WIDTH, the registered result.
REQ-010 The block SHALL have port cout, output, 1, the registered final carry (sub: 1 = no borrow).
REQ-011 The block SHALL have port ovf, output, 1, registered two's-complement overflow.

Function
REQ-012 The FSM SHALL have states IDLE, LOAD, SHIFT and DONE, and busy/done SHALL be Moore outputs.
REQ-013 IDLE: start=1 at an edge SHALL go to LOAD; otherwise remain in IDLE.
REQ-014 LOAD SHALL last exactly one cycle and then go to SHIFT unconditionally.
- Captures a, b and sub into internal shift registers.
- Sets carry = sub; sets bit counter = 0.
REQ-015 Each SHIFT cycle SHALL process the LSBs.
- bb = b[0] XOR sub; s = a[0] XOR bb XOR carry; carry <= majority(a[0], bb, carry).
- Operand registers shift right by one; s enters the result shift register at the MSB.
- Counter increments.
REQ-016 SHIFT SHALL last exactly WIDTH cycles, with a counter width of clog2(WIDTH+1), then go to DONE.
REQ-017 On the SHIFT->DONE edge, sum, cout and ovf SHALL load from the final result register and carries.
- ovf = carry-in of MSB XOR carry-out of MSB.
- Outputs hold until the next SHIFT->DONE edge.
REQ-018 DONE SHALL last one cycle: start=1 goes to LOAD (back-to-back operation), otherwise to IDLE.
REQ-019 start, a, b and sub SHALL be ignored in LOAD (except the capture) and in SHIFT; changes there do not affect the operation in flight.
REQ-020 Latency SHALL be fixed: start sampled at edge N gives LOAD in cycle N+1, SHIFT in N+2..N+WIDTH+1, and done=1 in cycle N+WIDTH+2.
REQ-021 Throughput SHALL be one result per WIDTH+2 cycles with start held high continuously.
REQ-022 Arithmetic SHALL wrap modulo 2^WIDTH; no saturation.

Reset
REQ-023 resetn=0 SHALL immediately force the following, independent of clk:
- State = IDLE.
- busy = 0, done = 0, sum = 0, cout = 0, ovf = 0.
- Internal operand, result, carry and counter registers cleared.
REQ-024 Reset asserted mid-LOAD or mid-SHIFT SHALL abort the operation with no done pulse and no output update.
REQ-025 After resetn deasserts, the first transition SHALL occur at the first rising clk edge with resetn=1.

Verification (WIDTH=8)
REQ-026 Add case:
- Stimulus: a=100, b=27, sub=0, start pulsed 1 cycle.
- Response: busy for 9 cycles, then done 1 cycle with sum=127, cout=0, ovf=0.
REQ-027 Unsigned wrap:
- Stimulus: a=200, b=100, sub=0.
- Response: sum=44, cout=1, ovf=0.
REQ-028 Subtract case:
- Stimulus: a=5, b=7, sub=1.
- Response: sum=254 (0xFE), cout=0, ovf=0.
- Also check a=7, b=5, sub=1: sum=2, cout=1.
REQ-029 Signed overflow:
- Stimulus: a=127, b=1, sub=0 gives sum=128, cout=0, ovf=1.
- Stimulus: a=128, b=1, sub=1 gives sum=127, ovf=1.
REQ-030 Back-to-back operation:
- Stimulus: start held high; a and b changed randomly during SHIFT.
- Response: done every 10 cycles; each result matches the operands captured in its LOAD.
REQ-031 Reset mid-operation:
- Stimulus: resetn low during the 4th SHIFT cycle.
- Response: all outputs 0 at once, no done pulse; the next operation after release gives the correct result.
